flag_bank_arbiter: RTL and testbench

FLAG_BANK_ARBITER -- requirements
Module: flag_bank_arbiter

---
 rtl/flag_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/flag_bank_arbiter.sv | 71 +++++++
 tb/tb_flag_bank_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// flag_pkg: op encodings and default sizing shared by the flag bank arbiter.
package flag_pkg;
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_CLR = 2'b01,
        OP_SET = 2'b10,
        OP_ILL = 2'b11
    } op_e;
    localparam int NREQ_DEF  = 4;
    localparam int NFLAG_DEF = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first requester at or above ptr wins.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    int   j;
    logic found;
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            j = (j >= N) ? j - N : j;
            if (!found && req[j[PW-1:0]]) begin
                gnt[j[PW-1:0]] = 1'b1;
                found          = 1'b1;
            end
        end
    end
endmodule

// File: rtl/flag_bank_arbiter.sv
// flag_bank_arbiter: round-robin shared SR flag bank with error reporting.
module flag_bank_arbiter import flag_pkg::*; #(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int NFLAG = NFLAG_DEF,
    localparam int IW    = (NFLAG > 1) ? $clog2(NFLAG) : 1,
    localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [2*NREQ-1:0]  req_op,
    input  logic [IW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]    req_ready,
    output logic [NFLAG-1:0]   flags,
    output logic               err,
    output logic [SW-1:0]      err_src,
    output logic [7:0]         err_cnt
);
    logic [NREQ-1:0]  gnt;
    logic [SW-1:0]    rr_ptr_q, rr_ptr_d, win;
    logic [NFLAG-1:0] flags_q, flags_d;
    logic             err_q;
    logic [SW-1:0]    err_src_q;
    logic [7:0]       err_cnt_q;
    logic             acc, bad;
    op_e              op_w;
    logic [IW-1:0]    idx_w;

    // Masking requests under reset keeps req_ready low and blocks acceptance.
    rr_arbiter #(.N(NREQ)) u_rr (
        .req (req_valid & {NREQ{~rst}}),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) win = SW'(i);
        acc      = |gnt;
        op_w     = op_e'(req_op[2*win +: 2]);
        idx_w    = req_idx[IW*win +: IW];
        bad      = acc && (op_w == OP_ILL || (op_w != OP_NOP && int'(idx_w) >= NFLAG));
        rr_ptr_d = !acc ? rr_ptr_q : (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        flags_d  = flags_q;
        if (acc && !bad && op_w == OP_SET) flags_d[idx_w] = 1'b1;
        if (acc && !bad && op_w == OP_CLR) flags_d[idx_w] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            flags_q   <= '0;
            err_q     <= 1'b0;
            err_src_q <= '0;
            err_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            flags_q   <= flags_d;
            err_q     <= bad;
            err_src_q <= bad ? win : err_src_q;
            err_cnt_q <= (bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        end
    end

    assign req_ready = gnt;
    assign flags     = flags_q;
    assign err       = err_q;
    assign err_src   = err_src_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_flag_bank_arbiter.sv
// tb_flag_bank_arbiter: directed checks on a default instance and an NFLAG=6 instance.
module tb_flag_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  v8, rdy8, v6, rdy6;
    logic [7:0]  op8, op6, f8;
    logic [11:0] idx8, idx6;
    logic [5:0]  f6;
    logic        e8, e6;
    logic [1:0]  es8, es6;
    logic [7:0]  ec8, ec6;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    flag_bank_arbiter u8 (
        .clk(clk), .rst(rst), .req_valid(v8), .req_op(op8), .req_idx(idx8),
        .req_ready(rdy8), .flags(f8), .err(e8), .err_src(es8), .err_cnt(ec8)
    );

    flag_bank_arbiter #(.NREQ(4), .NFLAG(6)) u6 (
        .clk(clk), .rst(rst), .req_valid(v6), .req_op(op6), .req_idx(idx6),
        .req_ready(rdy6), .flags(f6), .err(e6), .err_src(es6), .err_cnt(ec6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; v8 = 4'b1111; op8 = '0; idx8 = '0;
        v6 = '0; op6 = '0; idx6 = '0;
        tick();
        tick();
        chk("rst_ready", rdy8, 4'b0000);
        chk("rst_flags", f8, 8'h00);
        chk("rst_errcnt", ec8, 8'd0);
        chk("rst_err", e8, 1'b0);
        chk("rst_errsrc", es8, 2'd0);
        rst = 1'b0; v8 = '0;
        #1 chk("idle_ready", rdy8, 4'b0000);

        v8 = 4'b0100; op8[5:4] = 2'b10; idx8[8:6] = 3'd5;
        #1 chk("set5_ready", rdy8, 4'b0100);
        tick();
        chk("set5_flags", f8, 8'h20);
        chk("set5_err", e8, 1'b0);
        op8[5:4] = 2'b01;
        #1 chk("clr5_ready", rdy8, 4'b0100);
        tick();
        chk("clr5_flags", f8, 8'h00);

        rst = 1'b1; v8 = '0; op8 = '0; idx8 = '0;
        tick();
        rst = 1'b0; v8 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("fair_%0d", k), rdy8, 4'b0001 << (k % 4));
            tick();
        end
        chk("nop_no_err", ec8, 8'd0);
        chk("nop_flags", f8, 8'h00);

        v8 = 4'b0010; op8[3:2] = 2'b10; idx8[5:3] = 3'd3;
        tick();
        chk("set3_flags", f8, 8'h08);
        op8[3:2] = 2'b11;
        tick();
        chk("ill_flags", f8, 8'h08);
        chk("ill_err", e8, 1'b1);
        chk("ill_src", es8, 2'd1);
        chk("ill_cnt", ec8, 8'd1);
        v8 = '0;
        tick();
        chk("ill_err_pulse", e8, 1'b0);
        chk("ill_src_hold", es8, 2'd1);
        chk("ill_cnt_hold", ec8, 8'd1);

        v8 = 4'b0100; op8 = '0; op8[5:4] = 2'b10; idx8 = '0; idx8[8:6] = 3'd6;
        tick();
        chk("set6_other_hold", f8, 8'h48);

        v8 = 4'b0001; op8 = '0; op8[1:0] = 2'b10; idx8 = '0; rst = 1'b1;
        #1 chk("midrst_ready", rdy8, 4'b0000);
        tick();
        chk("midrst_flags", f8, 8'h00);
        chk("midrst_cnt", ec8, 8'd0);
        rst = 1'b0; v8 = 4'b1111; op8 = '0;
        #1 chk("midrst_ptr0", rdy8, 4'b0001);
        v8 = '0;

        v6 = 4'b0001; op6[1:0] = 2'b10; idx6[2:0] = 3'd2;
        tick();
        chk("n6_set2", f6, 6'h04);
        idx6[2:0] = 3'd7;
        tick();
        chk("n6_oor7_flags", f6, 6'h04);
        chk("n6_oor7_err", e6, 1'b1);
        chk("n6_oor7_src", es6, 2'd0);
        chk("n6_oor7_cnt", ec6, 8'd1);
        op6[1:0] = 2'b01; idx6[2:0] = 3'd6;
        tick();
        chk("n6_oor6_cnt", ec6, 8'd2);
        op6[1:0] = 2'b10; idx6[2:0] = 3'd5;
        tick();
        chk("n6_set5", f6, 6'h24);
        chk("n6_set5_err", e6, 1'b0);
        idx6[2:0] = 3'd7;
        for (int k = 0; k < 252; k++) tick();
        chk("n6_cnt254", ec6, 8'd254);
        for (int k = 0; k < 6; k++) tick();
        v6 = '0;
        tick();
        chk("n6_cnt_sat", ec6, 8'd255);
        chk("n6_sat_flags", f6, 6'h24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
